// File: rtl/retry_inorder_end.sv
// retry_inorder_end: closing stage of the in-order retry pair. Forwards only the
// awaited, fault-free element downstream and bounces everything else back to the
// start stage, so the consumer always sees elements in issue order.
module retry_inorder_end #(
  parameter type         DataType = logic,
  parameter int unsigned IDSize   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  DataType           data_i,
  input  logic [IDSize-1:0] id_i,
  input  logic              needs_retry_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [IDSize-1:0] retry_id_o,
  input  logic [IDSize-1:0] retry_id_i,
  output logic              retry_valid_o,
  output logic              retry_lock_o,
  input  logic              retry_ready_i,
  output logic [15:0]       fault_count_o
);

  // Sequence-count width; the top ID bit carries the parity of the count.
  localparam int unsigned CntW     = IDSize - 1;
  localparam logic [15:0] CountMax = 16'hFFFF;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_e;

  state_e            state;
  logic [IDSize-1:0] expected_q;
  logic              parity_ok;
  logic              id_match;
  logic              good;
  logic              accept;

  // Next ID in issue order: count + 1 (wrapping), parity recomputed over the count.
  function automatic logic [IDSize-1:0] incr_id(input logic [CntW-1:0] cnt);
    logic [CntW-1:0] nxt;
    nxt = cnt + CntW'(1);
    return {^nxt, nxt};
  endfunction

  // Classify the arriving element and steer it to the consumer or back to start.
  always_comb begin
    parity_ok     = (id_i[IDSize-1] == ^id_i[CntW-1:0]);
    id_match      = (id_i == expected_q);
    good          = !needs_retry_i && id_match && parity_ok;
    ready_o       = ready_i & retry_ready_i;
    accept        = valid_i & ready_o;
    data_o        = data_i;
    valid_o       = valid_i & good;
    retry_valid_o = valid_i & !good;
    retry_id_o    = id_i;
    // The combinational term bridges start's one-cycle registered lock.
    retry_lock_o  = (state == RECOVER) | retry_valid_o;
  end

  // Track the awaited ID, recovery state and the saturating fault counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= RUN;
      expected_q    <= '0;
      fault_count_o <= '0;
    end else if (accept) begin
      if (good) begin
        expected_q <= incr_id(expected_q[CntW-1:0]);
        state      <= RUN;
      end else begin
        // Only a failure of the awaited element moves the expectation to its re-issue ID.
        if (id_match) begin
          expected_q <= retry_id_i;
        end
        state <= RECOVER;
        if (fault_count_o != CountMax) begin
          fault_count_o <= fault_count_o + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_retry_inorder_end.sv
// Directed bench for retry_inorder_end with hand-computed expectations.
module tb_retry_inorder_end;

  logic       clk;
  logic       rst;
  logic [7:0] data_i;
  logic [3:0] id_i;
  logic       needs_retry_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic [3:0] retry_id_o;
  logic [3:0] retry_id_i;
  logic       retry_valid_o;
  logic       retry_lock_o;
  logic       retry_ready_i;
  logic [15:0] fault_count_o;

  int total;
  int bad;

  retry_inorder_end #(
    .DataType(logic [7:0]),
    .IDSize  (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data_i),
    .id_i         (id_i),
    .needs_retry_i(needs_retry_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .retry_id_o   (retry_id_o),
    .retry_id_i   (retry_id_i),
    .retry_valid_o(retry_valid_o),
    .retry_lock_o (retry_lock_o),
    .retry_ready_i(retry_ready_i),
    .fault_count_o(fault_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed and expected differ.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one element for a single accepted cycle and check its steering.
  task automatic xfer(input string tag, input logic [3:0] id, input logic nr,
                      input logic [3:0] rid, input logic [7:0] d,
                      input logic exp_good, input logic exp_lock);
    valid_i       = 1'b1;
    id_i          = id;
    needs_retry_i = nr;
    retry_id_i    = rid;
    data_i        = d;
    ready_i       = 1'b1;
    retry_ready_i = 1'b1;
    #1;
    check_val({tag, "/ready"},  32'(ready_o), 32'd1);
    check_val({tag, "/valid"},  32'(valid_o), 32'(exp_good));
    check_val({tag, "/rvalid"}, 32'(retry_valid_o), 32'(!exp_good));
    check_val({tag, "/lock"},   32'(retry_lock_o), 32'(exp_lock));
    if (exp_good) check_val({tag, "/data"}, 32'(data_o), 32'(d));
    else          check_val({tag, "/rid"},  32'(retry_id_o), 32'(id));
    step();
    valid_i = 1'b0;
  endtask

  // Idle cycle: no element, check lock level and fault counter.
  task automatic idle(input string tag, input logic exp_lock, input logic [15:0] exp_cnt);
    valid_i       = 1'b0;
    ready_i       = 1'b1;
    retry_ready_i = 1'b1;
    #1;
    check_val({tag, "/ivalid"},  32'(valid_o), 32'd0);
    check_val({tag, "/irvalid"}, 32'(retry_valid_o), 32'd0);
    check_val({tag, "/ilock"},   32'(retry_lock_o), 32'(exp_lock));
    check_val({tag, "/count"},   32'(fault_count_o), 32'(exp_cnt));
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    data_i        = '0;
    id_i          = '0;
    needs_retry_i = 1'b0;
    valid_i       = 1'b0;
    ready_i       = 1'b1;
    retry_id_i    = '0;
    retry_ready_i = 1'b1;
    #2;
    check_val("rst/valid",  32'(valid_o), 32'd0);
    check_val("rst/rvalid", 32'(retry_valid_o), 32'd0);
    check_val("rst/lock",   32'(retry_lock_o), 32'd0);
    check_val("rst/count",  32'(fault_count_o), 32'd0);
    check_val("rst/ready",  32'(ready_o), 32'd1);
    step();
    rst = 1'b0;
    step();

    // In-order fault-free stream 0,9,A,3.
    xfer("t1_0", 4'h0, 1'b0, 4'h0, 8'h10, 1'b1, 1'b0);
    xfer("t1_9", 4'h9, 1'b0, 4'h0, 8'h11, 1'b1, 1'b0);
    xfer("t1_A", 4'hA, 1'b0, 4'h0, 8'h12, 1'b1, 1'b0);
    xfer("t1_3", 4'h3, 1'b0, 4'h0, 8'h13, 1'b1, 1'b0);
    idle("t1", 1'b0, 16'd0);

    // Awaited 9 faults, re-issued as 3 and forwarded.
    do_reset();
    xfer("t2_0", 4'h0, 1'b0, 4'h0, 8'h20, 1'b1, 1'b0);
    xfer("t2_9", 4'h9, 1'b1, 4'h3, 8'h21, 1'b0, 1'b1);
    idle("t2_rec", 1'b1, 16'd1);
    xfer("t2_3", 4'h3, 1'b0, 4'h0, 8'h22, 1'b1, 1'b1);
    idle("t2_run", 1'b0, 16'd1);

    // C faults (re-issue F); in-flight 5,6 mismatch; then F wraps to 0, then 9.
    xfer("t3_C", 4'hC, 1'b1, 4'hF, 8'h30, 1'b0, 1'b1);
    xfer("t3_5", 4'h5, 1'b0, 4'h0, 8'h31, 1'b0, 1'b1);
    xfer("t3_6", 4'h6, 1'b0, 4'h0, 8'h32, 1'b0, 1'b1);
    idle("t3_rec", 1'b1, 16'd4);
    xfer("t3_F", 4'hF, 1'b0, 4'h0, 8'h33, 1'b1, 1'b1);
    xfer("t3_0", 4'h0, 1'b0, 4'h0, 8'h34, 1'b1, 1'b0);
    xfer("t3_9", 4'h9, 1'b0, 4'h0, 8'h35, 1'b1, 1'b0);
    idle("t3_run", 1'b0, 16'd4);

    // A faults (re-issue 3), re-issued 3 faults again (re-issue C), C good.
    xfer("t4_A", 4'hA, 1'b1, 4'h3, 8'h40, 1'b0, 1'b1);
    xfer("t4_3", 4'h3, 1'b1, 4'hC, 8'h41, 1'b0, 1'b1);
    idle("t4_rec", 1'b1, 16'd6);
    xfer("t4_C", 4'hC, 1'b0, 4'h0, 8'h42, 1'b1, 1'b1);
    idle("t4_run", 1'b0, 16'd6);

    // Bad parity: D is count 5 with flipped parity, 8 is count 0 with bad parity.
    xfer("t5_D", 4'hD, 1'b0, 4'h0, 8'h50, 1'b0, 1'b1);
    xfer("t5_8", 4'h8, 1'b0, 4'h0, 8'h51, 1'b0, 1'b1);
    idle("t5_rec", 1'b1, 16'd8);
    xfer("t5_5", 4'h5, 1'b0, 4'h0, 8'h52, 1'b1, 1'b1);
    idle("t5_run", 1'b0, 16'd8);

    // Downstream backpressure on a good element 6.
    valid_i = 1'b1; id_i = 4'h6; needs_retry_i = 1'b0; data_i = 8'h60;
    ready_i = 1'b0; retry_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val("t6_bp/ready", 32'(ready_o), 32'd0);
      check_val("t6_bp/valid", 32'(valid_o), 32'd1);
      check_val("t6_bp/data",  32'(data_o), 32'h60);
      check_val("t6_bp/lock",  32'(retry_lock_o), 32'd0);
      step();
    end
    ready_i = 1'b1; retry_ready_i = 1'b0;
    #1;
    check_val("t6_rr/ready", 32'(ready_o), 32'd0);
    step();
    xfer("t6_6", 4'h6, 1'b0, 4'h0, 8'h61, 1'b1, 1'b0);

    // Retry backpressure on a failing F: nothing accepted, counter holds.
    valid_i = 1'b1; id_i = 4'hF; needs_retry_i = 1'b1; retry_id_i = 4'h9;
    ready_i = 1'b1; retry_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("t6_rb/rvalid", 32'(retry_valid_o), 32'd1);
      check_val("t6_rb/lock",   32'(retry_lock_o), 32'd1);
      check_val("t6_rb/count",  32'(fault_count_o), 32'd8);
      step();
    end
    xfer("t6_F", 4'hF, 1'b1, 4'h9, 8'h62, 1'b0, 1'b1);
    idle("t6_rec", 1'b1, 16'd9);

    // Asynchronous reset in the middle of RECOVER.
    rst = 1'b1;
    #1;
    check_val("t6_rst/lock",  32'(retry_lock_o), 32'd0);
    check_val("t6_rst/count", 32'(fault_count_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    xfer("t6_0", 4'h0, 1'b0, 4'h0, 8'h63, 1'b1, 1'b0);
    xfer("t6_9", 4'h9, 1'b0, 4'h0, 8'h64, 1'b1, 1'b0);
    idle("t6_end", 1'b0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
